// File: rtl/avalonsemi_5401_pkg.sv
// Shared types for the 5401 CPU memory interface: command codes,
// FIFO geometry and the queued memory request bundle.
package avalonsemi_5401_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned ADDR_W     = 12;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_ADDR_LO = 2'b01,
        CMD_ADDR_HI = 2'b10,
        CMD_DATA    = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } st_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [3:0]        wdata;
    } req_t;

endpackage

// File: rtl/avalonsemi_5401_req_fifo.sv
// Four-entry request FIFO; a push while full is taken only
// when a pop frees the head slot in the same cycle.
module avalonsemi_5401_req_fifo
    import avalonsemi_5401_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  req_t             i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output req_t             o_head
);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    req_t             r_mem [FIFO_DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/avalonsemi_5401_mem_if.sv
// 5401 CPU io_out command decoder feeding a queued memory port.
// Define AVALONSEMI_5401_AUTOINC_EN to post-increment addr on DATA.
module avalonsemi_5401_mem_if
    import avalonsemi_5401_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        cpu_io_out,
    output logic [3:0]        cpu_data_in,
    output logic              cpu_ef0,
    output logic              cpu_ef1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wdata,
    input  logic [3:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              ovf
);

    logic [7:0]        r_cpu_q;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ovf;
    st_e               r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_wdata;
    logic [3:0]        r_rdata;
    logic              r_ef1;

    cmd_e              w_cmd;
    logic              w_exec;
    logic              w_data_cmd;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    req_t              w_req;
    req_t              w_head;
    req_t              w_next;
    logic              w_unused;

    assign w_cmd      = cmd_e'(r_cpu_q[7:6]);
    assign w_exec     = r_armed && (w_cmd != CMD_NOP);
    assign w_data_cmd = w_exec && (w_cmd == CMD_DATA);
    assign w_pop      = (r_state == ST_REQ) && mem_ready;
    assign w_push_ok  = w_data_cmd && (!w_full || w_pop);
    assign w_req      = '{addr: r_addr, we: r_cpu_q[5], wdata: r_cpu_q[3:0]};
    assign w_unused   = r_cpu_q[4];
    // Bypass the FIFO head when empty so a fresh push reaches the bus a cycle early
    assign w_next     = w_empty ? w_req : w_head;

    avalonsemi_5401_req_fifo u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_data  (w_req),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cpu_q <= '0;
            r_armed <= 1'b1;
            r_addr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_cpu_q <= cpu_io_out;
            if (w_cmd == CMD_NOP) begin
                r_armed <= 1'b1;
            end else if (w_exec) begin
                r_armed <= 1'b0;
            end
            if (w_exec && w_cmd == CMD_ADDR_LO) begin
                r_addr[5:0] <= r_cpu_q[5:0];
            end
            if (w_exec && w_cmd == CMD_ADDR_HI) begin
                r_addr[11:6] <= r_cpu_q[5:0];
            end
`ifdef AVALONSEMI_5401_AUTOINC_EN
            if (w_push_ok) begin
                r_addr <= r_addr + 12'd1;
            end
`endif
            if (w_data_cmd && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_ef1       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty || w_push_ok) begin
                        r_state     <= ST_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_next.we;
                        r_mem_addr  <= w_next.addr;
                        r_mem_wdata <= w_next.wdata;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                            r_ef1   <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A newly issued read invalidates any older completed data
            if (w_data_cmd && !r_cpu_q[5]) begin
                r_ef1 <= 1'b0;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_data_in = r_rdata;
    assign cpu_ef1     = r_ef1;
    assign ovf         = r_ovf;
    assign cpu_ef0     = (w_count != '0) || (r_state == ST_REQ);

endmodule

// File: doc/avalonsemi_5401_mem_if.md
AVALONSEMI_5401_MEM_IF -- requirements
Module: avalonsemi_5401_mem_if

Interface
REQ-001 The module SHALL have port CLK, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-002 The module SHALL have port RST, input, 1 bit, an asynchronous active-low reset.
REQ-003 The module SHALL have port cpu_io_out, input, 8 bits, driven directly by the 5401 CPU io_out bus.
REQ-004 The module SHALL have port cpu_data_in, output, 4 bits, the read-data nibble driven back to the CPU data_in.
REQ-005 The module SHALL have port cpu_ef0, output, 1 bit, busy: FIFO non-empty or memory transaction pending.
REQ-006 The module SHALL have port cpu_ef1, output, 1 bit, read data valid.
REQ-007 The module SHALL have ports mem_req, output, 1 bit, and mem_we, output, 1 bit, the memory request strobe and write qualifier.
REQ-008 The module SHALL have ports mem_addr, output, 12 bits, and mem_wdata, output, 4 bits, the memory address and write data.
REQ-009 The module SHALL have ports mem_rdata, input, 4 bits, and mem_ready, input, 1 bit, the memory read data and transfer-complete signal.
REQ-010 The module SHALL have port ovf, output, 1 bit, a sticky flag recording a dropped command.

Function
REQ-011 The module SHALL register cpu_io_out once (cpu_q) and decode only from cpu_q, with cmd = cpu_q[7:6]: 00 NOP, 01 ADDR_LO, 10 ADDR_HI, 11 DATA.
REQ-012 An armed flag SHALL be set whenever cmd==NOP; a non-NOP cmd SHALL execute exactly once, in the first cycle it appears while armed, after which armed SHALL clear; a held command SHALL NOT repeat.
REQ-013 ADDR_LO SHALL load addr[5:0]=cpu_q[5:0]; ADDR_HI SHALL load addr[11:6]=cpu_q[5:0].
REQ-014 DATA SHALL push {addr, we=cpu_q[5], wdata=cpu_q[3:0]} into a 4-entry request FIFO in the same cycle it executes; cpu_q[4] SHALL be ignored.
REQ-015 A DATA command with we=0 SHALL clear cpu_ef1 in the same cycle it executes.
REQ-016 Memory FSM states: IDLE and REQ. IDLE->REQ SHALL occur when the FIFO is non-empty; mem_req, mem_addr, mem_we and mem_wdata SHALL be driven from the FIFO head while in REQ.
REQ-017 In REQ with mem_ready=1 the FSM SHALL pop the head and return to IDLE; for a read it SHALL capture mem_rdata into the rdata register and set cpu_ef1.
REQ-018 Latency: a DATA command whose first cpu_io_out cycle is N, with the FIFO empty, SHALL see mem_req=1 in cycle N+2.
REQ-019 Full = 4 entries; a push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the command SHALL be dropped and ovf set.
REQ-020 FIFO pointers SHALL be 2 bits, wrap modulo 4, with a 3-bit count.
REQ-021 cpu_ef0 SHALL equal (count!=0) or (state==REQ).
REQ-022 cpu_data_in SHALL equal the rdata register at all times.

Reset
REQ-023 Reset SHALL asynchronously set cpu_q=0, armed=1, addr=0, FIFO empty, state=IDLE, rdata=0, cpu_ef1=0, ovf=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction and discard all FIFO entries.
REQ-025 Reset release SHALL take effect at the first rising edge of CLK after RST deasserts.

Configuration
REQ-026 With macro AVALONSEMI_5401_AUTOINC_EN defined, addr SHALL increment by 1 (wrapping 0xFFF->0x000) after every accepted DATA push; without it, addr SHALL change only on ADDR_LO or ADDR_HI.
REQ-027 With AVALONSEMI_5401_AUTOINC_EN defined, a dropped DATA command SHALL NOT increment addr.

Structure
REQ-028 Package avalonsemi_5401_pkg SHALL hold the command code constants, FIFO_DEPTH=4, ADDR_W=12, and the request struct {addr, we, wdata}.
REQ-029 The FIFO SHALL be a separate sub-module avalonsemi_5401_req_fifo with push, pop, full, empty, count and head ports.

Verification
REQ-030 The bench SHALL cover ADDR_LO 0x15, ADDR_HI 0x2A, DATA we=1 wdata=0x7 -> one mem_req with mem_addr=0xA95, mem_we=1, mem_wdata=0x7.
REQ-031 The bench SHALL cover DATA we=1 held 10 cycles, then NOP -> exactly one FIFO push and one memory transaction.
REQ-032 The bench SHALL cover a read at 0x123 with mem_ready delayed 3 cycles and mem_rdata=0xC -> cpu_data_in=0xC, cpu_ef1=1, cpu_ef0=0 afterwards.
REQ-033 The bench SHALL cover 5 writes with mem_ready held 0 -> first 4 queued, the 5th dropped, ovf=1, cpu_ef0=1.
REQ-034 The bench SHALL cover AUTOINC_EN on, addr 0xFFF, 2 writes -> mem_addr 0xFFF then 0x000; with the macro off, both at 0xFFF.
REQ-035 The bench SHALL cover RST asserted while in REQ with 3 entries queued -> mem_req=0 immediately, FIFO empty, no further requests after release.
